// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared constants, state encoding and source-page mapping for the OAM DMA engine.
// Optional feature macro: DMA_ECHO_MAP_EN (source pages E0..FF fold onto the WRAM echo).
package oam_dma_pkg;

    localparam logic [15:0] REG_DMA  = 16'hFF46;
    localparam int          OAM_SIZE = 160;

    typedef enum logic [1:0] {IDLE, START, XFER} state_e;

    function automatic logic [7:0] src_page(input logic [7:0] hi);
`ifdef DMA_ECHO_MAP_EN
        return (hi >= 8'hE0) ? (hi & 8'hDF) : hi;
`else
        return hi;
`endif
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU register port, source read bus and OAM write bus of the OAM DMA engine.
interface oam_dma_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_write;
    logic [7:0]  reg_data;
    logic        reg_data_active;
    logic        busy;
    logic [15:0] dma_addr;
    logic        dma_read;
    logic [7:0]  dma_data_in;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_write;

    modport master (
        input  cpu_addr, cpu_data_in, cpu_write, dma_data_in,
        output reg_data, reg_data_active, busy, dma_addr, dma_read, oam_addr, oam_data, oam_write
    );

    modport slave (
        output cpu_addr, cpu_data_in, cpu_write, dma_data_in,
        input  reg_data, reg_data_active, busy, dma_addr, dma_read, oam_addr, oam_data, oam_write
    );

endinterface

// File: rtl/oam_dma.sv
// oam_dma: copies a LENGTH-byte source page into OAM after a write to the DMA register.
// Optional feature macro: DMA_ECHO_MAP_EN (handled in oam_dma_pkg::src_page).
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] REG_ADDR        = REG_DMA,
    parameter int          LENGTH          = OAM_SIZE,
    parameter int          CYCLES_PER_BYTE = 4,
    parameter int          START_DELAY     = 4
) (
    input  logic       clk,
    input  logic       reset,
    oam_dma_if.master  bus
);

    state_e      state_q, state_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] dma_addr_q, dma_addr_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic [7:0]  oam_data_q, oam_data_d;
    logic        trig, rd, wr;

    assign trig                = bus.cpu_write && bus.cpu_addr == REG_ADDR;
    assign bus.reg_data        = reg_q;
    assign bus.reg_data_active = bus.cpu_addr == REG_ADDR;
    assign bus.busy            = state_q != IDLE;
    assign bus.dma_read        = rd;
    assign bus.oam_write       = wr;
    assign bus.dma_addr        = dma_addr_d;
    assign bus.oam_addr        = oam_addr_d;
    assign bus.oam_data        = oam_data_d;

    // Next state: start delay, per-byte slot sequencing, and a trigger that overrides everything.
    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q + 8'd1;
        rd         = 1'b0;
        wr         = 1'b0;
        case (state_q)
            START: if (cnt_q == 8'(START_DELAY - 1)) begin
                state_d = XFER;
                cnt_d   = '0;
            end
            XFER: begin
                rd = cnt_q == 8'd0;
                wr = cnt_q == 8'd1;
                if (cnt_q == 8'(CYCLES_PER_BYTE - 1)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == 8'(LENGTH - 1)) ? IDLE : XFER;
                end
            end
            default: cnt_d = cnt_q;
        endcase
        if (trig) begin
            state_d = START;
            reg_d   = bus.cpu_data_in;
            idx_d   = '0;
            cnt_d   = '0;
        end
        dma_addr_d = rd ? {src_page(reg_q), idx_q} : dma_addr_q;
        oam_addr_d = wr ? idx_q : oam_addr_q;
        oam_data_d = wr ? bus.dma_data_in : oam_data_q;
    end

    // State and held bus values; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            reg_q      <= 8'hFF;
            idx_q      <= '0;
            cnt_q      <= '0;
            dma_addr_q <= '0;
            oam_addr_q <= '0;
            oam_data_q <= '0;
        end else begin
            state_q    <= state_d;
            reg_q      <= reg_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            dma_addr_q <= dma_addr_d;
            oam_addr_q <= oam_addr_d;
            oam_data_q <= oam_data_d;
        end
    end

endmodule
